// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one debug UART transmitter
// between NREQ byte sources, paced by the transmitter busy flag.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned LOCK_TIMEOUT = 68000
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [NREQ-1:0]   grant_o,
    output logic              lock_o,
    output logic              timeout_o,
    output logic              uart_wr_o,
    output logic [7:0]        uart_dat_o,
    input  logic              uart_busy_i
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_d;
    logic              lock_d;
    logic              timeout_d;
    logic              wr_d;
    logic [7:0]        dat_d;

    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cand;

    // Pick the requester to serve this cycle: locked owner only, else first valid from rr_q.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        if (state_q == IDLE && !uart_busy_i) begin
            if (lock_o) begin
                sel_found = req_valid_i[owner_q];
                sel_idx   = owner_q;
            end else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    cand = IDX_W'((32'(rr_q) + k) % NREQ);
                    if (!sel_found && req_valid_i[cand]) begin
                        sel_found = 1'b1;
                        sel_idx   = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (sel_found && !sys_rst_i) begin
            req_ready_o[sel_idx] = 1'b1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        grant_d   = grant_o;
        lock_d    = lock_o;
        timeout_d = 1'b0;
        dat_d     = uart_dat_o;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = ISSUE;
                    dat_d   = req_data_i[{sel_idx, 3'b000} +: 8];
                    owner_d = sel_idx;
                    cnt_d   = '0;
                    if (req_last_i[sel_idx]) begin
                        lock_d  = 1'b0;
                        grant_d = '0;
                        rr_d    = (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
                    end else begin
                        lock_d  = 1'b1;
                        grant_d = NREQ'(1) << sel_idx;
                    end
                end else if (lock_o && !req_valid_i[owner_q]) begin
                    // Owner went quiet mid-packet; release after the idle budget.
                    if (cnt_q == CNT_MAX) begin
                        lock_d    = 1'b0;
                        grant_d   = '0;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        rr_d      = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ISSUE:   state_d = WAIT_HI;
            WAIT_HI: if (uart_busy_i)  state_d = WAIT_LO;
            WAIT_LO: if (!uart_busy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!lock_d) begin
            cnt_d = '0;
        end
        wr_d = (state_d == ISSUE);
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            grant_o    <= '0;
            lock_o     <= 1'b0;
            timeout_o  <= 1'b0;
            uart_wr_o  <= 1'b0;
            uart_dat_o <= 8'h00;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            grant_o    <= grant_d;
            lock_o     <= lock_d;
            timeout_o  <= timeout_d;
            uart_wr_o  <= wr_d;
            uart_dat_o <= dat_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;

    localparam int N          = 4;
    localparam int LT         = 16;
    localparam int BUSY_LEN   = 88;
    localparam int WAIT_BOUND = 2000;

    logic           clk  = 1'b0;
    logic           rst  = 1'b1;
    logic [N-1:0]   valid = '0;
    logic [N-1:0]   last  = '0;
    logic [8*N-1:0] data  = '0;
    logic           busy  = 1'b0;

    logic [N-1:0]   ready;
    logic [N-1:0]   grant;
    logic           lock;
    logic           tout;
    logic           wr;
    logic [7:0]     dat;

    uart_tx_arbiter #(.NREQ(N), .LOCK_TIMEOUT(LT)) dut (
        .sys_clk_i  (clk),
        .sys_rst_i  (rst),
        .req_valid_i(valid),
        .req_data_i (data),
        .req_last_i (last),
        .req_ready_o(ready),
        .grant_o    (grant),
        .lock_o     (lock),
        .timeout_o  (tout),
        .uart_wr_o  (wr),
        .uart_dat_o (dat),
        .uart_busy_i(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Abstract model: is a byte in flight, has the UART started it, who owns the link.
    bit         m_inflight, m_wlo, m_wr_due, m_to, m_locked;
    int         m_rr, m_owner, m_idle;
    logic [7:0] m_dat;

    logic [N-1:0] s_ready, s_grant;
    logic         s_lock, s_to, s_wr;
    logic [7:0]   s_dat;
    int           s_cyc;

    logic [7:0] log_q[$];
    int         wr_cyc[$];
    logic [N-1:0] drop_on_ack = '1;

    int bcnt  = 0;
    bit bpend = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_log(input string name, input int i, input logic [7:0] exp);
        if (i < log_q.size()) chk(name, 32'(log_q[i]), 32'(exp));
        else chk(name, 32'hFFFF_FFFF, 32'(exp));
    endtask

    task automatic model_reset();
        m_inflight = 0; m_wlo = 0; m_wr_due = 0; m_to = 0; m_locked = 0;
        m_rr = 0; m_owner = 0; m_idle = 0; m_dat = 8'h00;
    endtask

    task automatic compare_step();
        int sel;
        logic [N-1:0] er, eg;
        bit nwr, nto;
        s_ready = ready; s_grant = grant; s_lock = lock;
        s_to = tout; s_wr = wr; s_dat = dat; s_cyc = cyc;
        if (rst) begin
            chk("rst_ready",   32'(ready), 32'h0);
            chk("rst_grant",   32'(grant), 32'h0);
            chk("rst_lock",    32'(lock),  32'h0);
            chk("rst_timeout", 32'(tout),  32'h0);
            chk("rst_wr",      32'(wr),    32'h0);
            chk("rst_dat",     32'(dat),   32'h0);
            model_reset();
            return;
        end
        sel = -1;
        if (!m_inflight && !busy) begin
            if (m_locked) begin
                if (valid[m_owner]) sel = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (sel < 0 && valid[c]) sel = c;
                end
            end
        end
        er = '0;
        if (sel >= 0) er[sel] = 1'b1;
        eg = '0;
        if (m_locked) eg[m_owner] = 1'b1;
        chk("ready",   32'(ready), 32'(er));
        chk("grant",   32'(grant), 32'(eg));
        chk("lock",    32'(lock),  32'(m_locked));
        chk("timeout", 32'(tout),  32'(m_to));
        chk("wr",      32'(wr),    32'(m_wr_due));
        chk("dat",     32'(dat),   32'(m_dat));
        if (wr) begin
            log_q.push_back(dat);
            wr_cyc.push_back(cyc);
            chk("wr_while_busy", 32'(busy), 32'h0);
        end
        nwr = 0; nto = 0;
        if (m_wr_due) begin
        end else if (m_inflight) begin
            if (!m_wlo) begin
                if (busy) m_wlo = 1;
            end else if (!busy) begin
                m_inflight = 0;
            end
        end else if (sel >= 0) begin
            m_dat = data[8*sel +: 8];
            m_inflight = 1; m_wlo = 0; nwr = 1; m_idle = 0;
            if (last[sel]) begin
                m_locked = 0; m_rr = (sel + 1) % N;
            end else begin
                m_locked = 1; m_owner = sel;
            end
        end else if (m_locked && !valid[m_owner]) begin
            if (m_idle == LT - 1) begin
                m_locked = 0; m_rr = (m_owner + 1) % N; nto = 1; m_idle = 0;
            end else begin
                m_idle++;
            end
        end
        if (!m_locked) m_idle = 0;
        m_wr_due = nwr;
        m_to = nto;
    endtask

    // Transmitter stand-in: busy rises the cycle after the strobe, lasts BUSY_LEN cycles.
    task automatic uart_step();
        if (rst) begin
            busy = 1'b0; bcnt = 0; bpend = 0;
        end else begin
            if (bpend) begin
                busy = 1'b1; bcnt = BUSY_LEN; bpend = 0;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) busy = 1'b0;
            end
            if (wr) bpend = 1;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] hs;
        @(negedge clk);
        compare_step();
        hs = s_ready & valid;
        @(posedge clk);
        #1;
        cyc++;
        uart_step();
        for (int r = 0; r < N; r++) if (hs[r] && drop_on_ack[r]) valid[r] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = '0; last = '0; data = '0; drop_on_ack = '1;
        repeat (3) cycle();
        rst = 1'b0;
        log_q.delete();
        wr_cyc.delete();
    endtask

    task automatic run_until(input int n, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < WAIT_BOUND && !ok; i++) begin
            cycle();
            ok = (log_q.size() >= n);
        end
        chk({"wait_", name}, 32'(ok), 32'h1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < WAIT_BOUND && !ok; i++) begin
            cycle();
            ok = !m_inflight && !busy;
        end
        chk("wait_idle", 32'(ok), 32'h1);
    endtask

    initial begin
        logic [7:0] exp_fair [5];
        int n_acc, lock_chk, acc, to_cyc;
        bit got;

        model_reset();

        // Fairness: everyone valid, single-byte packets.
        do_reset();
        drop_on_ack = '0;
        for (int r = 0; r < N; r++) begin
            valid[r] = 1'b1; last[r] = 1'b1; data[8*r +: 8] = 8'(8'h10 + r);
        end
        run_until(5, "fair");
        valid = '0; drop_on_ack = '1;
        exp_fair = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        for (int i = 0; i < 5; i++) chk_log("fair_order", i, exp_fair[i]);
        for (int i = 0; i < 4; i++) begin
            if (i + 1 < wr_cyc.size()) chk("fair_spacing", 32'(wr_cyc[i+1] - wr_cyc[i]), 32'(BUSY_LEN + 3));
            else chk("fair_spacing", 32'hFFFF_FFFF, 32'(BUSY_LEN + 3));
        end
        wait_idle();

        // Single source r=2, then prove rr moved to 3.
        do_reset();
        valid[2] = 1'b1; last[2] = 1'b1; data[23:16] = 8'h41;
        cycle();
        chk("single_ready", 32'(s_ready), 32'h4);
        cycle();
        chk("single_ready_off", 32'(s_ready), 32'h0);
        chk("single_wr",   32'(s_wr),   32'h1);
        chk("single_dat",  32'(s_dat),  32'h41);
        chk("single_lock", 32'(s_lock), 32'h0);
        wait_idle();
        valid[0] = 1'b1; last[0] = 1'b1; data[7:0]   = 8'h50;
        valid[3] = 1'b1; last[3] = 1'b1; data[31:24] = 8'h53;
        run_until(3, "rr");
        chk_log("rr_first",  1, 8'h53);
        chk_log("rr_second", 2, 8'h50);
        wait_idle();

        // Packet lock: r=1 three-byte packet while r=0 waits.
        do_reset();
        drop_on_ack = 4'b1101;
        valid[1] = 1'b1; last[1] = 1'b0; data[15:8] = 8'hA0;
        n_acc = 0; lock_chk = 0;
        for (int i = 0; i < WAIT_BOUND && n_acc < 3; i++) begin
            cycle();
            if (lock_chk > 0) begin
                chk("pkt_lock",  32'(s_lock),  (lock_chk < 3) ? 32'h1 : 32'h0);
                chk("pkt_grant", 32'(s_grant), (lock_chk < 3) ? 32'h2 : 32'h0);
                lock_chk = 0;
            end
            if (s_ready[1]) begin
                n_acc++;
                lock_chk = n_acc;
                if (n_acc == 1) begin
                    valid[0] = 1'b1; last[0] = 1'b1; data[7:0] = 8'h30;
                end
                if (n_acc < 3) begin
                    data[15:8] = 8'(8'hA0 + n_acc); last[1] = (n_acc == 2);
                end else begin
                    valid[1] = 1'b0;
                end
            end
        end
        chk("pkt_accepts", 32'(n_acc), 32'h3);
        cycle();
        chk("pkt_lock_end", 32'(s_lock), 32'h0);
        run_until(4, "pkt");
        chk_log("pkt_b0", 0, 8'hA0);
        chk_log("pkt_b1", 1, 8'hA1);
        chk_log("pkt_b2", 2, 8'hA2);
        chk_log("pkt_b3", 3, 8'h30);
        wait_idle();

        // Lock timeout: r=3 opens a packet and goes quiet; r=0/r=1 wait.
        do_reset();
        valid[3] = 1'b1; last[3] = 1'b0; data[31:24] = 8'h77;
        cycle();
        chk("to_acc_ready", 32'(s_ready), 32'h8);
        acc = s_cyc;
        valid[0] = 1'b1; last[0] = 1'b1; data[7:0]  = 8'h60;
        valid[1] = 1'b1; last[1] = 1'b1; data[15:8] = 8'h61;
        cycle();
        chk("to_grant", 32'(s_grant), 32'h8);
        chk("to_lock",  32'(s_lock),  32'h1);
        got = 0; to_cyc = 0;
        for (int i = 0; i < WAIT_BOUND && !got; i++) begin
            cycle();
            if (s_to) begin
                got = 1; to_cyc = s_cyc;
            end
        end
        chk("to_seen",      32'(got),          32'h1);
        chk("to_delay",     32'(to_cyc - acc), 32'(BUSY_LEN + 19));
        chk("to_lock_rel",  32'(s_lock),       32'h0);
        chk("to_grant_rel", 32'(s_grant),      32'h0);
        cycle();
        chk("to_one_pulse", 32'(s_to), 32'h0);
        run_until(3, "to");
        chk_log("to_b0", 0, 8'h77);
        chk_log("to_b1", 1, 8'h60);
        chk_log("to_b2", 2, 8'h61);
        wait_idle();

        // Reset while the UART is mid-byte.
        do_reset();
        valid[1] = 1'b1; last[1] = 1'b1; data[15:8] = 8'h11;
        run_until(1, "rst_a");
        wait_idle();
        valid[3] = 1'b1; last[3] = 1'b0; data[31:24] = 8'h93;
        got = 0;
        for (int i = 0; i < WAIT_BOUND && !got; i++) begin
            cycle();
            got = m_inflight && m_wlo;
        end
        chk("rst_reach_wait_lo", 32'(got), 32'h1);
        repeat (5) cycle();
        chk("pre_rst_lock",  32'(s_lock),  32'h1);
        chk("pre_rst_grant", 32'(s_grant), 32'h8);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_grant", 32'(grant), 32'h0);
        chk("async_rst_lock",  32'(lock),  32'h0);
        chk("async_rst_dat",   32'(dat),   32'h0);
        chk("async_rst_wr",    32'(wr),    32'h0);
        chk("async_rst_ready", 32'(ready), 32'h0);
        repeat (3) cycle();
        rst = 1'b0;
        valid[1] = 1'b1; last[1] = 1'b1; data[15:8]  = 8'h21;
        valid[3] = 1'b1; last[3] = 1'b1; data[31:24] = 8'h23;
        cycle();
        chk("post_rst_ready", 32'(s_ready), 32'h2);
        run_until(4, "post_rst");
        chk_log("post_rst_b0", 2, 8'h21);
        chk_log("post_rst_b1", 3, 8'h23);
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single 115200-baud debug UART transmitter between up to NREQ byte sources: firmware console, error reporter, statistics dumper and others. Grants are round-robin at packet granularity, so a multi-byte message from one source is never interleaved with another's. The block drives the transmitter's write strobe and data byte, and paces itself on the transmitter's busy flag. It sits between the requesting blocks and the UART.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- LOCK_TIMEOUT, 68000: idle cycles a locked owner may leave req_valid_i low before its lock is forcibly released (≥2).

Ports:
- sys_clk_i  in  1  system clock, 68 MHz.
- sys_rst_i  in  1  reset, asynchronous and active-high.
- req_valid_i  in  NREQ  requester r has a byte on its data lane.
- req_data_i  in  8*NREQ  byte lanes; lane r is bits [8r+7:8r].
- req_last_i  in  NREQ  byte on lane r is the last one of its packet.
- req_ready_o  out  NREQ  accept strobe, one-hot or zero. The byte transfers when req_valid_i[r] & req_ready_o[r].
- grant_o  out  NREQ  one-hot current owner, registered; zero when no owner.
- lock_o  out  1  a packet is in progress (owner held).
- timeout_o  out  1  one-cycle pulse when a lock is force-released.
- uart_wr_o  out  1  write strobe to the transmitter, registered.
- uart_dat_o  out  8  byte to the transmitter, registered.
- uart_busy_i  in  1  transmitter busy flag.

## Operation
- State machine: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- IDLE, selection when uart_busy_i=0:
  - If lock_o=1, only the owner is eligible.
  - Otherwise the first r with req_valid_i[r]=1 is chosen, searching from rr_ptr upward and wrapping modulo NREQ.
  - If uart_busy_i=1, nothing is selected.
- req_ready_o[r] is combinational and high only in IDLE, for the selected r, the same cycle req_valid_i[r]=1.
- On accept:
  - uart_dat_o <= lane r.
  - grant_o <= onehot(r).
  - lock_o <= ~req_last_i[r].
  - If req_last_i[r]=1: rr_ptr <= (r+1) mod NREQ and grant_o <= 0.
  - Go to ISSUE.
- ISSUE: uart_wr_o=1 for exactly this one cycle; go to WAIT_HI.
- WAIT_HI: stay until uart_busy_i=1, then go to WAIT_LO.
- WAIT_LO: stay until uart_busy_i=0, then go to IDLE.
- Lock timeout:
  - Counter runs only in IDLE while lock_o=1 and the owner's req_valid_i=0.
  - Counter clears on any accept or when lock_o=0.
  - When the count reaches LOCK_TIMEOUT-1: lock_o<=0, grant_o<=0, rr_ptr<=(owner+1) mod NREQ, timeout_o=1 for one cycle.
  - Counter width is clog2(LOCK_TIMEOUT).
- Valid from a non-owner while locked is ignored. It is neither dropped nor acked.
- A single-byte packet (last=1 on its first byte) never sets lock_o.

## Timing
- Reset (asynchronous, any state) forces:
  - state=IDLE, rr_ptr=0, counter=0.
  - uart_wr_o=0, uart_dat_o=0x00.
  - grant_o=0, lock_o=0, timeout_o=0.
  - req_ready_o=0 while in reset.
  - A byte in flight is abandoned. The transmitter shares the reset.
- Accept cycle T (IDLE) leads to uart_wr_o=1 at T+1 (ISSUE). The transmitter raises busy at T+2.
- uart_dat_o is stable from T+1 until the next accept.
- Minimum spacing between accepts is ISSUE + WAIT_HI + WAIT_LO duration + 1 IDLE cycle. This is about 1 byte time, roughly 5900 cycles at 68 MHz / 115200.
- uart_wr_o is never asserted while uart_busy_i=1 at the preceding IDLE decision.
- Simultaneous events:
  - All requesters valid: round-robin order from rr_ptr.
  - Accept and timeout cannot coincide; accept wins because the counter clears.
  - req_valid_i dropping without a handshake is legal; no byte is consumed.
- rr_ptr wraps NREQ-1 → 0.

## Test plan
- Single source: r=2 sends 0x41 with last=1 → req_ready_o=4'b0100 for 1 cycle, uart_wr_o pulses next cycle with uart_dat_o=0x41, lock_o stays 0, rr_ptr=3.
- Fairness: all 4 hold valid with last=1 on every byte, bytes 0x10+r → UART byte order 0x10,0x11,0x12,0x13,0x10.
- Packet lock: r=1 sends 0xA0,0xA1,0xA2 (last on 0xA2) while r=0 holds valid → UART order 0xA0,0xA1,0xA2 then r=0's byte; lock_o high from the first accept until the 0xA2 accept.
- Busy pacing: model the transmitter with an 11-bit-time busy → exactly one uart_wr_o per busy period; no strobe while busy=1; accepts at least 1 byte time apart.
- Lock timeout with LOCK_TIMEOUT=16: r=3 sends a byte with last=0, then drops valid → timeout_o pulses after 16 idle cycles, lock_o=0, grant_o=0, r=0 served next.
- Reset mid-byte: assert sys_rst_i in WAIT_LO → all outputs zero immediately (asynchronous); after release the first accept starts the search from r=0.
